// File: rtl/branch_predict_d_pkg.sv
// Shared definitions for the decode-stage branch predictor:
// redirect PC sources and BTB entry field geometry.
package branch_predict_d_pkg;

  typedef enum logic [2:0] {
    PC_SRC_NONE,
    PC_SRC_ERR,
    PC_SRC_ERET,
    PC_SRC_TARGET,
    PC_SRC_SEQ
  } pc_src_e;

  localparam int BTB_VALID_W = 1;

  function automatic int btb_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int btb_tag_w(input int xlen, input int depth);
    return xlen - $clog2(depth) - 2;
  endfunction

  function automatic int btb_entry_w(input int xlen, input int depth,
                                     input int cnt_w);
    return BTB_VALID_W + btb_tag_w(xlen, depth) + xlen + cnt_w;
  endfunction

endpackage

// File: rtl/branch_predict_d_btb_table.sv
// Direct-mapped BTB with per-entry saturating counters.
// Lookup is combinational and sees pre-update contents.
module btb_table
  import branch_predict_d_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = btb_idx_w(BTB_DEPTH);
  localparam int TAG_W = btb_tag_w(XLEN, BTB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WEAK =
    {1'b1, {(CNT_W-1){1'b0}}};

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [XLEN-1:0]      tgt_q [BTB_DEPTH];
  logic [CNT_W-1:0]     cnt_q [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[XLEN-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : '0;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CNT_W-1:0] cnt_nxt;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    cnt_nxt = cnt_q[up_idx];
    if (upd_taken && cnt_q[up_idx] != CNT_MAX)
      cnt_nxt = cnt_q[up_idx] + CNT_ONE;
    else if (!upd_taken && cnt_q[up_idx] != '0)
      cnt_nxt = cnt_q[up_idx] - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        cnt_q[up_idx] <= cnt_nxt;
        if (upd_taken)
          tgt_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        // Taken miss evicts whatever aliased here.
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target;
        cnt_q[up_idx]   <= CNT_WEAK;
      end
    end
  end

endmodule

// File: rtl/branch_predict_d.sv
// Decode-stage branch resolution: BTB prediction for fetch,
// redirect/flush selection and branch performance counters.
module branch_predict_d
  import branch_predict_d_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int BTB_DEPTH  = 16,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [XLEN-1:0] f_pred_target,
  input  logic            d_valid,
  input  logic            d_stall,
  input  logic [XLEN-1:0] d_pc,
  input  logic            d_btype,
  input  logic            d_taken,
  input  logic [XLEN-1:0] d_target,
  input  logic            d_pred_taken,
  input  logic [XLEN-1:0] d_pred_target,
  input  logic            err_pc_ready,
  input  logic            eret_pc_ready,
  input  logic [XLEN-1:0] err_vec,
  input  logic [XLEN-1:0] epc,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_f,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam logic [XLEN-1:0] FT_OFS =
    (DELAY_SLOT != 0) ? XLEN'(8) : XLEN'(4);

  logic resolve;
  logic mispred;

  assign resolve = d_valid && d_btype && !d_stall;
  assign mispred = resolve &&
    ((d_pred_taken != d_taken) ||
     (d_taken && d_pred_target != d_target));

  btb_table #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH),
    .CNT_W     (CNT_W)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lk_pc       (f_pc),
    .pred_taken  (f_pred_taken),
    .pred_target (f_pred_target),
    .upd_en      (resolve),
    .upd_pc      (d_pc),
    .upd_taken   (d_taken),
    .upd_target  (d_target)
  );

  logic sel_err, sel_eret, sel_tgt, sel_seq;

  assign sel_err  = err_pc_ready;
  assign sel_eret = !err_pc_ready && eret_pc_ready;
  assign sel_tgt  = !err_pc_ready && !eret_pc_ready &&
                    mispred && d_taken;
  assign sel_seq  = !err_pc_ready && !eret_pc_ready &&
                    mispred && !d_taken;

  pc_src_e pc_src;

  always_comb begin
    pc_src = PC_SRC_NONE;
    unique case (1'b1)
      sel_err:  pc_src = PC_SRC_ERR;
      sel_eret: pc_src = PC_SRC_ERET;
      sel_tgt:  pc_src = PC_SRC_TARGET;
      sel_seq:  pc_src = PC_SRC_SEQ;
      default:  pc_src = PC_SRC_NONE;
    endcase
  end

  always_comb begin
    redirect_pc = '0;
    unique case (pc_src)
      PC_SRC_ERR:    redirect_pc = err_vec;
      PC_SRC_ERET:   redirect_pc = epc;
      PC_SRC_TARGET: redirect_pc = d_target;
      PC_SRC_SEQ:    redirect_pc = d_pc + FT_OFS;
      default:       redirect_pc = '0;
    endcase
  end

  assign redirect = (pc_src != PC_SRC_NONE);
  assign flush_f  = redirect;

  logic [31:0] br_q, mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (resolve && br_q != '1)
        br_q <= br_q + 32'd1;
      if (mispred && mis_q != '1)
        mis_q <= mis_q + 32'd1;
    end
  end

  assign br_count      = br_q;
  assign mispred_count = mis_q;

endmodule

// File: tb/tb_branch_predict_d.sv
// Directed and randomized checks of branch_predict_d against
// an array-based model of the BTB and redirect rules.
module tb_branch_predict_d;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        d_valid, d_stall, d_btype, d_taken, d_pred_taken;
  logic [31:0] d_pc, d_target, d_pred_target;
  logic        err_pc_ready, eret_pc_ready;
  logic [31:0] err_vec, epc;
  logic        redirect, flush_f;
  logic [31:0] redirect_pc, br_count, mispred_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predict_d dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .f_pc          (f_pc),
    .f_pred_taken  (f_pred_taken),
    .f_pred_target (f_pred_target),
    .d_valid       (d_valid),
    .d_stall       (d_stall),
    .d_pc          (d_pc),
    .d_btype       (d_btype),
    .d_taken       (d_taken),
    .d_target      (d_target),
    .d_pred_taken  (d_pred_taken),
    .d_pred_target (d_pred_target),
    .err_pc_ready  (err_pc_ready),
    .eret_pc_ready (eret_pc_ready),
    .err_vec       (err_vec),
    .epc           (epc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush_f       (flush_f),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  // Model: 16 direct-mapped entries, 2-bit counters, pc+8 fall-through.
  bit          m_v   [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int          m_cnt [16];
  longint      m_br, m_mis;

  function automatic int m_idx(input int unsigned pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned m_tg(input int unsigned pc);
    return pc / 64;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic m_lookup(input int unsigned pc, output bit t,
                          output int unsigned tg);
    int i;
    i = m_idx(pc);
    t = m_v[i] && m_tag[i] == m_tg(pc) && m_cnt[i] >= 2;
    tg = t ? m_tgt[i] : 0;
  endtask

  function automatic bit m_resolve();
    return d_valid && d_btype && !d_stall;
  endfunction

  function automatic bit m_mispred();
    return m_resolve() && (d_pred_taken != d_taken ||
      (d_taken && d_pred_target != d_target));
  endfunction

  task automatic m_update();
    int i;
    bit hit;
    i = m_idx(d_pc);
    hit = m_v[i] && m_tag[i] == m_tg(d_pc);
    if (m_mispred()) m_mis = (m_mis < 64'hFFFF_FFFF) ? m_mis + 1 : m_mis;
    m_br = (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
    if (hit) begin
      m_cnt[i] = d_taken ? (m_cnt[i] < 3 ? m_cnt[i] + 1 : 3)
                         : (m_cnt[i] > 0 ? m_cnt[i] - 1 : 0);
      if (d_taken) m_tgt[i] = d_target;
    end else if (d_taken) begin
      m_v[i] = 1; m_tag[i] = m_tg(d_pc);
      m_tgt[i] = d_target; m_cnt[i] = 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare combinational outputs with the model (inputs already driven).
  task automatic settle();
    bit          pt;
    int unsigned ptg;
    int unsigned rpc;
    bit          rd;
    #1;
    m_lookup(f_pc, pt, ptg);
    rd = 1;
    if (err_pc_ready)       rpc = err_vec;
    else if (eret_pc_ready) rpc = epc;
    else if (m_mispred())   rpc = d_taken ? d_target : d_pc + 8;
    else begin rd = 0; rpc = 0; end
    chk("f_pred_taken",  {31'd0, f_pred_taken}, {31'd0, pt});
    chk("f_pred_target", f_pred_target, ptg);
    chk("redirect",      {31'd0, redirect}, {31'd0, rd});
    chk("flush_f",       {31'd0, flush_f}, {31'd0, rd});
    chk("redirect_pc",   redirect_pc, rpc);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && m_resolve()) m_update();
    #1;
    chk("br_count",      br_count, m_br[31:0]);
    chk("mispred_count", mispred_count, m_mis[31:0]);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] pc);
    d_valid = 0; d_btype = 0; d_stall = 0; d_taken = 0;
    d_pc = 0; d_target = 0; d_pred_taken = 0; d_pred_target = 0;
    f_pc = pc;
  endtask

  task automatic br(input logic [31:0] pc, input logic tk,
                    input logic [31:0] tg, input logic pt,
                    input logic [31:0] ptg);
    d_valid = 1; d_btype = 1; d_stall = 0; d_pc = pc;
    d_taken = tk; d_target = tg;
    d_pred_taken = pt; d_pred_target = ptg;
  endtask

  logic [31:0] tgt_pool [4];
  bit          rp;
  int unsigned rtg;

  initial begin
    tgt_pool[0] = 32'h0040_0100; tgt_pool[1] = 32'h0040_0200;
    tgt_pool[2] = 32'h0000_1000; tgt_pool[3] = 32'h0040_0104;
    rst_n = 0;
    err_pc_ready = 0; eret_pc_ready = 0;
    err_vec = 32'h8000_0180; epc = 32'h0040_0800;
    idle(32'h0040_0000);
    m_clear();
    #2;
    chk("rst_f_pred", {31'd0, f_pred_taken}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_br", br_count, 32'd0);
    chk("rst_mis", mispred_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // First taken branch misses and allocates.
    idle(32'h0040_0000);
    br(32'h0040_0010, 1, 32'h0040_0100, 0, 0);
    settle();
    chk("a_pred", {31'd0, f_pred_taken}, 32'd0);
    chk("a_rpc", redirect_pc, 32'h0040_0100);
    tick();
    chk("a_br", br_count, 32'd1);
    chk("a_mis", mispred_count, 32'd1);

    // Hit predicts taken; correct prediction strengthens to 3.
    idle(32'h0040_0010);
    settle();
    chk("b_pred", {31'd0, f_pred_taken}, 32'd1);
    chk("b_tgt", f_pred_target, 32'h0040_0100);
    br(32'h0040_0010, 1, 32'h0040_0100, 1, 32'h0040_0100);
    settle();
    chk("b_redirect", {31'd0, redirect}, 32'd0);
    tick();

    // Two not-taken resolutions: 3 -> 2 still taken, 2 -> 1 not.
    br(32'h0040_0010, 0, 0, 1, 32'h0040_0100);
    settle();
    chk("c_rpc", redirect_pc, 32'h0040_0018);
    tick();
    idle(32'h0040_0010);
    settle();
    chk("c_pred_cnt2", {31'd0, f_pred_taken}, 32'd1);
    br(32'h0040_0010, 0, 0, 1, 32'h0040_0100);
    settle();
    chk("d_rpc", redirect_pc, 32'h0040_0018);
    tick();
    idle(32'h0040_0010);
    settle();
    chk("d_pred_cnt1", {31'd0, f_pred_taken}, 32'd0);

    // Error vector wins but update and count still happen.
    err_pc_ready = 1;
    eret_pc_ready = 1;
    br(32'h0040_0010, 1, 32'h0040_0100, 0, 0);
    settle();
    chk("e_rpc_err", redirect_pc, 32'h8000_0180);
    tick();
    chk("e_mis", mispred_count, 32'd4);
    err_pc_ready = 0;
    idle(32'h0040_0010);
    settle();
    chk("e_rpc_eret", redirect_pc, 32'h0040_0800);
    chk("e_pred_cnt2", {31'd0, f_pred_taken}, 32'd1);
    eret_pc_ready = 0;

    // Stalled branch does nothing.
    br(32'h0040_0050, 1, 32'h0040_0200, 0, 0);
    d_stall = 1;
    settle();
    chk("f_redirect", {31'd0, redirect}, 32'd0);
    tick();
    chk("f_br", br_count, 32'd5);
    chk("f_mis", mispred_count, 32'd4);
    idle(32'h0040_0050);
    settle();
    chk("f_pred_50", {31'd0, f_pred_taken}, 32'd0);

    // Aliasing PC evicts the 0x00400010 entry.
    br(32'h0040_0050, 1, 32'h0040_0200, 0, 0);
    settle();
    tick();
    idle(32'h0040_0010);
    settle();
    chk("g_evicted", {31'd0, f_pred_taken}, 32'd0);
    idle(32'h0040_0050);
    settle();
    chk("g_tgt", f_pred_target, 32'h0040_0200);

    // Same-index lookup and update: lookup sees old contents.
    br(32'h0040_0050, 0, 0, 1, 32'h0040_0200);
    f_pc = 32'h0040_0050;
    settle();
    chk("h_pre_update", {31'd0, f_pred_taken}, 32'd1);
    tick();
    idle(32'h0040_0050);
    settle();
    chk("h_post_update", {31'd0, f_pred_taken}, 32'd0);

    // Randomized traffic over a small PC pool with aliasing.
    for (int n = 0; n < 600; n++) begin
      f_pc = 32'h0040_0000 + 4 * $urandom_range(0, 23);
      if ($urandom_range(0, 3) == 0) f_pc = f_pc + 32'h0000_1000;
      d_pc = 32'h0040_0000 + 4 * $urandom_range(0, 23);
      if ($urandom_range(0, 3) == 0) d_pc = d_pc + 32'h0000_1000;
      d_valid = ($urandom_range(0, 9) != 0);
      d_btype = ($urandom_range(0, 9) < 7);
      d_stall = ($urandom_range(0, 9) < 2);
      d_taken = $urandom_range(0, 1);
      d_target = tgt_pool[$urandom_range(0, 3)];
      m_lookup(d_pc, rp, rtg);
      if ($urandom_range(0, 3) != 0) begin
        d_pred_taken = rp; d_pred_target = rtg;
      end else begin
        d_pred_taken = $urandom_range(0, 1);
        d_pred_target = tgt_pool[$urandom_range(0, 3)];
      end
      err_pc_ready  = ($urandom_range(0, 9) == 0);
      eret_pc_ready = ($urandom_range(0, 9) == 0);
      err_vec = $urandom;
      epc = $urandom;
      settle();
      tick();
      // Occasional reset with a live resolution pending.
      if (n == 300) begin
        br(32'h0040_0010, 1, 32'h0040_0100, 0, 0);
        err_pc_ready = 0; eret_pc_ready = 0;
        f_pc = d_pc;
        #2 rst_n = 0;
        m_clear();
        #1;
        chk("r_br", br_count, 32'd0);
        chk("r_mis", mispred_count, 32'd0);
        chk("r_pred", {31'd0, f_pred_taken}, 32'd0);
        tick();
        rst_n = 1;
        idle(32'h0040_0010);
        settle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
